vrp_arb_rr: RTL and testbench
=============================

Name: vrp_arb_rr

Overview:
Parametrised N-to-1 valid/ready arbiter for payload streams.
- Successor to the combinational fixed-priority arbiter.
- Adds selectable round-robin fairness, packet lock on a per-source last flag, an optional registered output stage, and the granted source index.
- Sits wherever several request queues share one downstream channel.

Parameters:
- WIDTH, 8, number of source channels (>=1, any integer, not restricted to powers of 2).
- PLD_WIDTH, 32, payload width in bits.
- ARB_MODE, 1, 0 = fixed priority (index 0 highest), 1 = round robin.
- LOCK_EN, 1, 1 = hold grant from a non-last beat until the last beat; 0 = each beat arbitrated independently.
- OUT_REG, 1, 1 = registered output stage; 0 = combinational pass-through.
- IDX_W, max(1,$clog2(WIDTH)), derived, index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- v_vld_s  in  WIDTH  source valids.
- v_pld_s  in  PLD_WIDTH x WIDTH (unpacked array)  source payloads.
- v_last_s  in  WIDTH  source last-beat flags.
- v_rdy_s  out  WIDTH  source readies; one-hot or zero.
- vld_m  out  1  master valid.
- pld_m  out  PLD_WIDTH  master payload.
- last_m  out  1  master last flag.
- idx_m  out  IDX_W  index of the source that supplied the current master beat.
- rdy_m  in  1  master ready.

Behaviour:
- Interface: one clock clk; reset rst is synchronous, active-high.
- Source transfer: v_vld_s[i] && v_rdy_s[i]. Master transfer: vld_m && rdy_m.
- accept = rdy_m when OUT_REG=0; accept = !out_vld_q || rdy_m when OUT_REG=1.
- Request mask: when lock_q=1, only lock_idx_q may be granted; otherwise all sources.
- Pick:
  - Round robin: lowest valid index >= ptr_q among masked requests; if none, lowest valid index overall.
  - Fixed mode: ptr_q is held at 0.
- v_rdy_s[i] = grant[i] && accept && !rst. v_rdy_s is combinational on v_vld_s and rdy_m; this is permitted.
- Pointer: on a source transfer from i with (v_last_s[i] || !LOCK_EN), ptr_q <= (i+1 == WIDTH) ? 0 : i+1. Otherwise unchanged.
- Lock (LOCK_EN=1):
  - Source transfer from i with last=0: lock_q <= 1, lock_idx_q <= i.
  - Transfer from lock_idx_q with last=1: lock_q <= 0.
  - If the locked source drops valid, the lock holds and no other source is granted.
- OUT_REG=0: vld_m = |(masked valids); pld_m, last_m and idx_m come from the picked source via one-hot mux. Latency 0.
- OUT_REG=1:
  - Stage loads {pld, last, idx} and sets out_vld_q on any source transfer.
  - Clears out_vld_q on a master transfer with no simultaneous load.
  - Simultaneous unload and load gives a back-to-back beat.
  - Latency 1 cycle, throughput 1 beat/cycle.
  - vld_m/pld_m held stable until rdy_m.
- Reset (synchronous):
  - ptr_q=0, lock_q=0, lock_idx_q=0, out_vld_q=0, out payload/last/idx=0.
  - During rst: v_rdy_s=0 and vld_m=0 in both OUT_REG modes.
  - Reset mid-packet drops the lock; any beat in the output stage is discarded.
- Boundaries:
  - WIDTH=1: grant = v_vld_s[0]; ptr stays 0.
  - Pointer wraps WIDTH-1 -> 0, including non-power-of-2 WIDTH.
  - No valid sources: v_rdy_s=0; ptr and lock unchanged.

Decomposition:
- Shared package vrp_arb_pkg: ARB_FIXED=0 and ARB_RR=1 constants; idx width function.
- Sub-module vrp_arb_pick: combinational rotated-priority picker; inputs are request vector and pointer; outputs are one-hot grant and index.
- Payload mux reuses cmn_real_mux_onehot over {pld,last,idx}.

Test Plan:
- RR, WIDTH=4, all valid continuously, last=1, rdy_m=1 -> idx_m sequence 0,1,2,3,0; one beat per cycle; with OUT_REG=1 the first vld_m appears 1 cycle after first v_rdy_s.
- Fixed mode, sources 1 and 3 always valid -> only source 1 ever granted; v_rdy_s=4'b0010 each cycle.
- Lock: source 2 sends 3 beats (last=0,0,1) while source 0 is valid; source 2 idles 2 cycles mid-packet -> source 0 not granted until source 2's last beat; then ptr=3 and source 0 granted next.
- Backpressure OUT_REG=1: rdy_m=0 for 5 cycles with a beat loaded -> vld_m=1 and pld_m stable; v_rdy_s=0; no beat lost or duplicated (scoreboard).
- Wrap, WIDTH=5: only source 4 then source 0 valid -> ptr goes 4 -> 0 -> 1.
- Reset mid-packet: rst pulsed while locked on source 1 with stage full -> next cycle vld_m=0, lock cleared, source 0 granted first (ptr=0).

Source files
------------

// File: rtl/vrp_arb_pkg.sv
// Shared constants and helpers for the vrp_arb valid/ready arbiter family.
package vrp_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int idx_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/cmn_real_mux_onehot.sv
// One-hot AND-OR multiplexer; an all-zero select yields an all-zero output.
module cmn_real_mux_onehot #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic [N-1:0] sel,
    input  logic [W-1:0] din [N],
    output logic [W-1:0] dout
);

    // OR together every input whose select bit is set
    always_comb begin
        dout = '0;
        for (int i = 0; i < N; i++) begin
            dout = dout | ({W{sel[i]}} & din[i]);
        end
    end

endmodule

// File: rtl/vrp_arb_pick.sv
// Rotated-priority picker: lowest request at or above ptr, else lowest request overall.
module vrp_arb_pick
    import vrp_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [WIDTH-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic             hit_hi_s;
    logic             hit_lo_s;
    logic [IDX_W-1:0] idx_hi_s;
    logic [IDX_W-1:0] idx_lo_s;

    // Scan downward so the last hit recorded is the lowest index of each range
    always_comb begin
        hit_hi_s = 1'b0;
        hit_lo_s = 1'b0;
        idx_hi_s = '0;
        idx_lo_s = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                hit_lo_s = 1'b1;
                idx_lo_s = IDX_W'(i);
                if (IDX_W'(i) >= ptr) begin
                    hit_hi_s = 1'b1;
                    idx_hi_s = IDX_W'(i);
                end else begin
                    hit_hi_s = hit_hi_s;
                end
            end else begin
                hit_lo_s = hit_lo_s;
            end
        end
    end

    // Prefer the range above the pointer, then expand the index to one-hot
    always_comb begin
        gnt = '0;
        any = hit_lo_s;
        if (hit_hi_s) begin
            idx = idx_hi_s;
        end else begin
            idx = idx_lo_s;
        end
        for (int i = 0; i < WIDTH; i++) begin
            gnt[i] = any && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/vrp_arb_rr.sv
// N-to-1 valid/ready arbiter: fixed or round-robin priority, packet lock, optional output register.
module vrp_arb_rr
    import vrp_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PLD_WIDTH = 32,
    parameter int ARB_MODE  = ARB_RR,
    parameter int LOCK_EN   = 1,
    parameter int OUT_REG   = 1,
    parameter int IDX_W     = idx_w(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     v_vld_s,
    input  logic [PLD_WIDTH-1:0] v_pld_s [WIDTH],
    input  logic [WIDTH-1:0]     v_last_s,
    output logic [WIDTH-1:0]     v_rdy_s,
    output logic                 vld_m,
    output logic [PLD_WIDTH-1:0] pld_m,
    output logic                 last_m,
    output logic [IDX_W-1:0]     idx_m,
    input  logic                 rdy_m
);

    localparam int BEAT_W = PLD_WIDTH + 1 + IDX_W;

    logic [IDX_W-1:0]  ptr_r;
    logic              lock_r;
    logic [IDX_W-1:0]  lock_idx_r;
    logic [WIDTH-1:0]  mask_s;
    logic [WIDTH-1:0]  req_s;
    logic [WIDTH-1:0]  gnt_s;
    logic [IDX_W-1:0]  pick_idx_s;
    logic              any_s;
    logic              accept_s;
    logic              xfer_s;
    logic              stage_busy_s;
    logic              sel_last_s;
    logic [BEAT_W-1:0] beat_s [WIDTH];
    logic [BEAT_W-1:0] sel_beat_s;

    // While a packet is open only its source may compete
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask_s[i] = !lock_r || (lock_idx_r == IDX_W'(i));
        end
        req_s = v_vld_s & mask_s;
    end

    vrp_arb_pick #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req_s),
        .ptr (ptr_r),
        .gnt (gnt_s),
        .idx (pick_idx_s),
        .any (any_s)
    );

    // Pack each source beat with its own index so the mux carries idx along
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            beat_s[i] = {v_pld_s[i], v_last_s[i], IDX_W'(i)};
        end
    end

    cmn_real_mux_onehot #(
        .N (WIDTH),
        .W (BEAT_W)
    ) u_mux (
        .sel  (gnt_s),
        .din  (beat_s),
        .dout (sel_beat_s)
    );

    assign sel_last_s = sel_beat_s[IDX_W];

    // Source handshake: the picked source is readied only when the beat can move on
    always_comb begin
        if (OUT_REG != 0) begin
            accept_s = !stage_busy_s || rdy_m;
        end else begin
            accept_s = rdy_m;
        end
        if (rst) begin
            v_rdy_s = '0;
            xfer_s  = 1'b0;
        end else if (accept_s) begin
            v_rdy_s = gnt_s;
            xfer_s  = any_s;
        end else begin
            v_rdy_s = '0;
            xfer_s  = 1'b0;
        end
    end

    // Arbitration state: rotating pointer advances past a finished packet
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r      <= '0;
            lock_r     <= 1'b0;
            lock_idx_r <= '0;
        end else if (xfer_s) begin
            if ((ARB_MODE == ARB_RR) && (sel_last_s || (LOCK_EN == 0))) begin
                if (pick_idx_s == IDX_W'(WIDTH - 1)) begin
                    ptr_r <= '0;
                end else begin
                    ptr_r <= pick_idx_s + IDX_W'(1);
                end
            end
            if (LOCK_EN != 0) begin
                if (sel_last_s) begin
                    lock_r <= 1'b0;
                end else begin
                    lock_r     <= 1'b1;
                    lock_idx_r <= pick_idx_s;
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            logic              out_vld_r;
            logic [BEAT_W-1:0] out_beat_r;

            // Output register: loads every accepted beat, drains on master ready
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_vld_r  <= 1'b0;
                    out_beat_r <= '0;
                end else if (xfer_s) begin
                    out_vld_r  <= 1'b1;
                    out_beat_r <= sel_beat_s;
                end else if (rdy_m) begin
                    out_vld_r <= 1'b0;
                end
            end

            assign stage_busy_s = out_vld_r;

            // Master side is driven straight from the register
            always_comb begin
                vld_m                  = out_vld_r && !rst;
                {pld_m, last_m, idx_m} = out_beat_r;
            end
        end else begin : g_comb
            assign stage_busy_s = 1'b0;

            // Zero-latency pass-through of the picked source
            always_comb begin
                vld_m                  = any_s && !rst;
                {pld_m, last_m, idx_m} = sel_beat_s;
            end
        end
    endgenerate

endmodule

// File: tb/tb_vrp_arb_rr.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-level reference model.
module tb_vrp_arb_rr;

    localparam int RW = 5;
    localparam int FW = 4;
    localparam int PW = 16;

    logic clk;
    logic rst;

    logic [RW-1:0] rr_vld, rr_last, rr_vrdy;
    logic [PW-1:0] rr_pld [RW];
    logic          rr_vldm, rr_lastm, rr_rdy;
    logic [PW-1:0] rr_pldm;
    logic [2:0]    rr_idxm;

    logic [FW-1:0] fx_vld, fx_last, fx_vrdy;
    logic [PW-1:0] fx_pld [FW];
    logic          fx_vldm, fx_lastm, fx_rdy;
    logic [PW-1:0] fx_pldm;
    logic [1:0]    fx_idxm;

    logic [0:0]    one_vld, one_last, one_vrdy;
    logic [PW-1:0] one_pld [1];
    logic          one_vldm, one_lastm, one_rdy;
    logic [PW-1:0] one_pldm;
    logic [0:0]    one_idxm;

    int n_chk = 0;
    int n_bad = 0;
    bit fx_dir = 1'b0;

    int            m_ptr, m_lidx, m_oidx;
    bit            m_lock, m_ov, m_olast;
    logic [PW-1:0] m_opld;
    logic [PW-1:0] held;

    vrp_arb_rr #(.WIDTH(RW), .PLD_WIDTH(PW), .ARB_MODE(1), .LOCK_EN(1), .OUT_REG(1)) u_rr (
        .clk(clk), .rst(rst), .v_vld_s(rr_vld), .v_pld_s(rr_pld), .v_last_s(rr_last),
        .v_rdy_s(rr_vrdy), .vld_m(rr_vldm), .pld_m(rr_pldm), .last_m(rr_lastm),
        .idx_m(rr_idxm), .rdy_m(rr_rdy));

    vrp_arb_rr #(.WIDTH(FW), .PLD_WIDTH(PW), .ARB_MODE(0), .LOCK_EN(0), .OUT_REG(0)) u_fx (
        .clk(clk), .rst(rst), .v_vld_s(fx_vld), .v_pld_s(fx_pld), .v_last_s(fx_last),
        .v_rdy_s(fx_vrdy), .vld_m(fx_vldm), .pld_m(fx_pldm), .last_m(fx_lastm),
        .idx_m(fx_idxm), .rdy_m(fx_rdy));

    vrp_arb_rr #(.WIDTH(1), .PLD_WIDTH(PW), .ARB_MODE(1), .LOCK_EN(1), .OUT_REG(0)) u_one (
        .clk(clk), .rst(rst), .v_vld_s(one_vld), .v_pld_s(one_pld), .v_last_s(one_last),
        .v_rdy_s(one_vrdy), .vld_m(one_vldm), .pld_m(one_pldm), .last_m(one_lastm),
        .idx_m(one_idxm), .rdy_m(one_rdy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge and refresh background stimulus
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < RW; i++) rr_pld[i] = PW'($urandom);
        for (int i = 0; i < FW; i++) fx_pld[i] = PW'($urandom);
        one_pld[0] = PW'($urandom);
        one_vld    = 1'($urandom);
        one_last   = 1'($urandom);
        one_rdy    = ($urandom_range(0, 3) != 0);
        if (!fx_dir) begin
            fx_vld  = FW'($urandom);
            fx_last = FW'($urandom);
            fx_rdy  = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Compare all instances at the falling edge, then advance the models
    task automatic eval();
        int g;
        logic [RW-1:0] er;
        logic [FW-1:0] ef;
        @(negedge clk);
        g = -1;
        if (!rst) begin
            for (int k = 0; k < RW; k++) begin
                if (g < 0 && rr_vld[(m_ptr + k) % RW] && (!m_lock || ((m_ptr + k) % RW) == m_lidx))
                    g = (m_ptr + k) % RW;
            end
        end
        er = '0;
        if (g >= 0 && (!m_ov || rr_rdy)) er[g] = 1'b1;
        chk("rr_rdy", rr_vrdy, er);
        chk("rr_vld", rr_vldm, m_ov && !rst);
        if (m_ov && !rst) begin
            chk("rr_pld", rr_pldm, m_opld);
            chk("rr_last", rr_lastm, m_olast);
            chk("rr_idx", rr_idxm, m_oidx);
        end
        if (rst) begin
            m_ptr = 0; m_lock = 0; m_lidx = 0; m_ov = 0;
        end else if (er != '0) begin
            if (rr_last[g]) begin
                m_ptr  = (g + 1) % RW;
                m_lock = 0;
            end else begin
                m_lock = 1;
                m_lidx = g;
            end
            m_ov = 1; m_opld = rr_pld[g]; m_olast = rr_last[g]; m_oidx = g;
        end else if (rr_rdy) begin
            m_ov = 0;
        end

        g = -1;
        for (int k = FW - 1; k >= 0; k--) if (fx_vld[k]) g = k;
        ef = '0;
        if (g >= 0 && fx_rdy && !rst) ef[g] = 1'b1;
        chk("fx_rdy", fx_vrdy, ef);
        chk("fx_vld", fx_vldm, (g >= 0) && !rst);
        if (g >= 0 && !rst) begin
            chk("fx_pld", fx_pldm, fx_pld[g]);
            chk("fx_last", fx_lastm, fx_last[g]);
            chk("fx_idx", fx_idxm, g);
        end

        chk("one_rdy", one_vrdy, one_vld && one_rdy && !rst);
        chk("one_vld", one_vldm, one_vld && !rst);
        if (one_vld && !rst) begin
            chk("one_pld", one_pldm, one_pld[0]);
            chk("one_idx", one_idxm, 0);
        end
    endtask

    task automatic step(input logic [RW-1:0] v, input logic [RW-1:0] l, input logic r, input logic rs);
        tick();
        rst = rs; rr_vld = v; rr_last = l; rr_rdy = r;
        eval();
    endtask

    initial begin
        logic [RW-1:0] oh;
        rst = 1'b1; rr_vld = '0; rr_last = '0; rr_rdy = 1'b0;
        fx_vld = '0; fx_last = '0; fx_rdy = 1'b0;
        one_vld = '0; one_last = '0; one_rdy = 1'b0;
        for (int i = 0; i < RW; i++) rr_pld[i] = '0;
        for (int i = 0; i < FW; i++) fx_pld[i] = '0;
        one_pld[0] = '0;
        m_ptr = 0; m_lock = 0; m_lidx = 0; m_ov = 0; m_olast = 0; m_oidx = 0; m_opld = '0;

        step(5'b11111, 5'b11111, 1'b1, 1'b1);
        chk("rst_vld", rr_vldm, 1'b0);
        chk("rst_rdy", rr_vrdy, 5'b00000);
        step(5'b00000, 5'b11111, 1'b1, 1'b1);

        // All sources busy: one grant per cycle in index order, master one cycle behind
        fx_dir = 1'b1; fx_vld = 4'b1010; fx_last = 4'b1111; fx_rdy = 1'b1;
        for (int c = 0; c < 7; c++) begin
            step(5'b11111, 5'b11111, 1'b1, 1'b0);
            oh = '0; oh[c % RW] = 1'b1;
            chk("seq_rdy", rr_vrdy, oh);
            chk("seq_vld", rr_vldm, c >= 1);
            if (c >= 1) chk("seq_idx", rr_idxm, (c - 1) % RW);
            chk("fixed_rdy", fx_vrdy, 4'b0010);
        end
        fx_dir = 1'b0;

        // Packet lock on source 2 with a two-cycle gap while source 0 waits
        step(5'b00100, 5'b00000, 1'b1, 1'b0); chk("lock_a", rr_vrdy, 5'b00100);
        step(5'b00001, 5'b00000, 1'b1, 1'b0); chk("lock_b", rr_vrdy, 5'b00000);
        step(5'b00001, 5'b00000, 1'b1, 1'b0); chk("lock_c", rr_vrdy, 5'b00000);
        step(5'b00101, 5'b00000, 1'b1, 1'b0); chk("lock_d", rr_vrdy, 5'b00100);
        step(5'b00101, 5'b00100, 1'b1, 1'b0); chk("lock_e", rr_vrdy, 5'b00100);
        step(5'b00101, 5'b11111, 1'b1, 1'b0); chk("lock_f", rr_vrdy, 5'b00001);

        // Backpressure: loaded beat must sit unchanged while rdy_m is low
        step(5'b00010, 5'b11111, 1'b1, 1'b0); chk("bp_load", rr_vrdy, 5'b00010);
        held = rr_pld[1];
        for (int c = 0; c < 5; c++) begin
            step(5'b00010, 5'b11111, 1'b0, 1'b0);
            chk("bp_rdy", rr_vrdy, 5'b00000);
            chk("bp_vld", rr_vldm, 1'b1);
            chk("bp_pld", rr_pldm, held);
            chk("bp_idx", rr_idxm, 3'd1);
        end
        step(5'b00010, 5'b11111, 1'b1, 1'b0);
        chk("bp_b2b", rr_vrdy, 5'b00010);
        chk("bp_out", rr_pldm, held);

        // Pointer wrap on a non-power-of-two width
        step(5'b10000, 5'b11111, 1'b1, 1'b0); chk("wrap_4", rr_vrdy, 5'b10000);
        step(5'b01001, 5'b11111, 1'b1, 1'b0); chk("wrap_0", rr_vrdy, 5'b00001);
        step(5'b01001, 5'b11111, 1'b1, 1'b0); chk("wrap_1", rr_vrdy, 5'b01000);

        // Reset while locked on source 1 with the output stage full
        step(5'b00010, 5'b00000, 1'b1, 1'b0); chk("rl_lock", rr_vrdy, 5'b00010);
        step(5'b00011, 5'b00000, 1'b0, 1'b0); chk("rl_full", rr_vrdy, 5'b00000);
        step(5'b00011, 5'b00000, 1'b1, 1'b1);
        chk("rl_rst_rdy", rr_vrdy, 5'b00000);
        chk("rl_rst_vld", rr_vldm, 1'b0);
        step(5'b00011, 5'b00000, 1'b1, 1'b0);
        chk("rl_after_vld", rr_vldm, 1'b0);
        chk("rl_after_rdy", rr_vrdy, 5'b00001);

        for (int c = 0; c < 3000; c++) begin
            step(RW'($urandom), RW'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 63) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
